// File: rtl/pueo_l2_scaler_pkg.sv
// rtl/pueo_l2_scaler_pkg.sv - shared constants for the level-two scaler block
package pueo_l2_scaler_pkg;

    localparam int NCHAN  = 24;
    localparam int NSECT  = 12;
    localparam int HPOL   = 0;
    localparam int VPOL   = 1;
    localparam int ADDR_W = 5;

    localparam int ADDR_TRIG = NCHAN;
    localparam int ADDR_SEQ  = NCHAN + 1;

    function automatic int sect_idx(input int pol, input int sect);
        return pol * NSECT + sect;
    endfunction

endpackage

// File: rtl/pueo_l2_scaler_if.sv
// rtl/pueo_l2_scaler_if.sv - housekeeping read bus of the level-two scaler
interface pueo_l2_scaler_if
    import pueo_l2_scaler_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);
    logic                 rd_i;
    logic [ADDR_W-1:0]    addr_i;
    logic [CNT_WIDTH-1:0] dat_o;
    logic                 valid_o;

    modport master (output rd_i, output addr_i, input dat_o, input valid_o);
    modport slave  (input rd_i, input addr_i, output dat_o, output valid_o);
endinterface

// File: rtl/pueo_sat_counter.sv
// rtl/pueo_sat_counter.sv - saturating event counter with synchronous clear
module pueo_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] next
);

    // next is what the shadow bank latches, so it must include this cycle's event
    assign next = (&cnt) ? cnt : cnt + WIDTH'(inc);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else
            cnt <= next;
    end

endmodule

// File: rtl/pueo_l2_scaler.sv
// rtl/pueo_l2_scaler.sv - gated leveltwo/trigger scalers with shadow read bank
module pueo_l2_scaler
    import pueo_l2_scaler_pkg::*;
#(
    parameter int NCHAN        = pueo_l2_scaler_pkg::NCHAN,
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NCHAN-1:0]        scal_i,
    input  logic                    trig_i,
    input  logic                    pps_i,
    input  logic                    gate_sel_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    update_o,
    pueo_l2_scaler_if.slave         rd_bus
);

    localparam logic [ADDR_W-1:0] A_TRIG = ADDR_W'(NCHAN);
    localparam logic [ADDR_W-1:0] A_SEQ  = ADDR_W'(NCHAN + 1);

    logic [NCHAN:0]          inc_v;
    logic [CNT_WIDTH-1:0]    cnt_live_unused [0:NCHAN];
    logic [CNT_WIDTH-1:0]    cnt_next        [0:NCHAN];
    logic [CNT_WIDTH-1:0]    shadow          [0:NCHAN];
    logic [CNT_WIDTH-1:0]    seq;
    logic [PERIOD_WIDTH-1:0] timer;
    logic                    pps_q;
    logic                    int_gate;
    logic                    gate;
    logic [CNT_WIDTH-1:0]    rd_data;

    assign inc_v = {trig_i, scal_i};

    for (genvar k = 0; k <= NCHAN; k++) begin : g_cnt
        pueo_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (inc_v[k]),
            .clr   (gate),
            .cnt   (cnt_live_unused[k]),
            .next  (cnt_next[k])
        );
    end

    // >= rather than == so shrinking the period below the timer fires at once
    assign int_gate = !gate_sel_i && (period_i != '0)
                      && (timer >= period_i - PERIOD_WIDTH'(1));
    assign gate     = gate_sel_i ? (pps_i & ~pps_q) : int_gate;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer <= '0;
            pps_q <= 1'b1;
        end else begin
            pps_q <= pps_i;
            if (gate_sel_i || period_i == '0 || int_gate)
                timer <= '0;
            else
                timer <= timer + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NCHAN; k++)
                shadow[k] <= '0;
            seq      <= '0;
            update_o <= 1'b0;
        end else begin
            update_o <= gate;
            if (gate) begin
                for (int k = 0; k <= NCHAN; k++)
                    shadow[k] <= cnt_next[k];
                seq <= seq + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_bus.addr_i <= A_TRIG)
            rd_data = shadow[rd_bus.addr_i];
        else if (rd_bus.addr_i == A_SEQ)
            rd_data = seq;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_bus.dat_o   <= '0;
            rd_bus.valid_o <= 1'b0;
        end else begin
            rd_bus.valid_o <= rd_bus.rd_i;
            if (rd_bus.rd_i)
                rd_bus.dat_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_pueo_l2_scaler.sv
// tb/tb_pueo_l2_scaler.sv - scoreboard bench for pueo_l2_scaler
module tb_pueo_l2_scaler;
    import pueo_l2_scaler_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCHAN-1:0]  scal;
    logic              trig;
    logic              pps;
    logic              gate_sel;
    logic [31:0]       period;
    logic              update;

    pueo_l2_scaler_if #(.CNT_WIDTH(16)) rbus ();

    pueo_l2_scaler #(.NCHAN(NCHAN), .CNT_WIDTH(16), .PERIOD_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scal_i     (scal),
        .trig_i     (trig),
        .pps_i      (pps),
        .gate_sel_i (gate_sel),
        .period_i   (period),
        .update_o   (update),
        .rd_bus     (rbus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] exp;
    } rd_exp_t;

    rd_exp_t sb[$];
    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int upd_cnt = 0;
    int upd_cyc = -1;
    int u0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc < t && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != t) chk("wait_cyc", cyc, t);
    endtask

    task automatic do_read(input int a, input int exp);
        rd_exp_t e;
        e.addr = 5'(a);
        e.exp  = 16'(exp);
        rbus.rd_i   = 1'b1;
        rbus.addr_i = 5'(a);
        sb.push_back(e);
        tick(1);
        rbus.rd_i = 1'b0;
    endtask

    always @(posedge clk) begin
        rd_exp_t e;
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
        #1;
        if (update) begin
            upd_cnt = upd_cnt + 1;
            upd_cyc = cyc;
        end
        if (rbus.valid_o) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rd_a%0d", e.addr), rbus.dat_o, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b1; scal = '0; trig = 1'b0; pps = 1'b0;
        gate_sel = 1'b0; period = 32'd100;
        rbus.rd_i = 1'b0; rbus.addr_i = '0;
        tick(3);
        chk("rst_valid", rbus.valid_o, 0);
        chk("rst_update", update, 0);
        chk("rst_dat", rbus.dat_o, 0);

        // internal gate, 7 flags on sector 3
        rst = 1'b0;
        tick(10);
        for (int i = 0; i < 7; i++) begin
            scal[3] = 1'b1; tick(1);
            scal[3] = 1'b0; tick(1);
        end
        wait_cyc(100);
        chk("t1_upd_cnt", upd_cnt, 1);
        chk("t1_upd_cyc", upd_cyc, 100);
        do_read(3, 7);
        do_read(4, 0);
        do_read(ADDR_TRIG, 0);
        do_read(ADDR_SEQ, 1);
        do_read(26, 0);

        // flag on the gate cycle plus a read on the shadow-load edge
        wait_cyc(199);
        scal[0] = 1'b1;
        do_read(0, 0);
        scal[0] = 1'b0;
        do_read(0, 1);
        do_read(3, 0);
        do_read(ADDR_SEQ, 2);
        chk("t3_upd_cyc", upd_cyc, 200);
        wait_cyc(300);
        chk("t3_upd_cnt", upd_cnt, 3);
        do_read(0, 0);
        do_read(ADDR_SEQ, 3);

        // reset mid-interval discards partial counts
        rst = 1'b1; tick(2); rst = 1'b0;
        tick(5);
        for (int i = 0; i < 5; i++) begin
            scal[sect_idx(HPOL, 10)] = 1'b1; tick(1);
            scal[sect_idx(HPOL, 10)] = 1'b0; tick(1);
        end
        tick(10);
        u0 = upd_cnt;
        rst = 1'b1; tick(2); rst = 1'b0;
        tick(50);
        chk("t6_no_upd", upd_cnt, u0);
        do_read(10, 0);
        do_read(ADDR_TRIG, 0);
        do_read(ADDR_SEQ, 0);
        wait_cyc(100);
        chk("t6_upd_cyc", upd_cyc, 100);
        do_read(10, 0);
        do_read(ADDR_SEQ, 1);

        // PPS mode: no edge out of reset while pps is high, then saturation
        gate_sel = 1'b1; pps = 1'b1;
        rst = 1'b1; tick(3); rst = 1'b0;
        u0 = upd_cnt;
        tick(20);
        chk("pps_rst_edge", upd_cnt, u0);
        pps = 1'b0;
        trig = 1'b1; tick(66000); trig = 1'b0;
        tick(5);
        chk("sat_no_upd", upd_cnt, u0);
        for (int p = 0; p < 3; p++) begin
            pps = 1'b1;
            tick(3);
            if (p == 0)      do_read(ADDR_TRIG, 65535);
            else if (p == 1) do_read(ADDR_TRIG, 5);
            else             do_read(ADDR_SEQ, 3);
            tick(6);
            pps = 1'b0;
            if (p == 0) begin
                tick(10);
                for (int i = 0; i < 5; i++) begin
                    trig = 1'b1; tick(1);
                    trig = 1'b0; tick(1);
                end
                tick(970);
            end else begin
                tick(990);
            end
        end
        chk("pps_upd_cnt", upd_cnt - u0, 3);

        tick(5);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
